half_adder: RTL and testbench
=============================

HALF_ADDER -- requirements
Module: half_adder

Interface
REQ-001 Parameter WIDTH, default 1: number of independent single-bit half-adder lanes (legal range 1..64).
REQ-002 Parameter CNT_W, default 16: width of the carry event counter.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port a, input, WIDTH: addend A, one bit per lane.
REQ-006 Port b, input, WIDTH: addend B, one bit per lane.
REQ-007 Port in_valid, input, 1: a and b are sampled on this cycle when high.
REQ-008 Port s, output, WIDTH: registered sum, one bit per lane.
REQ-009 Port c, output, WIDTH: registered carry, one bit per lane.
REQ-010 Port out_valid, output, 1: s and c hold a new result this cycle.
REQ-011 Port cnt_clr, input, 1: synchronous clear of carry_cnt; present only with HALF_ADDER_CARRY_CNT_EN.
REQ-012 Port carry_cnt, output, CNT_W: running count of lanes producing carry; present only with HALF_ADDER_CARRY_CNT_EN.

Function
REQ-013 Per lane i: sum = a[i] XOR b[i]; carry = a[i] AND b[i]. Lanes are fully independent, with no carry propagation between lanes.
REQ-014 Latency is exactly 1 cycle: when in_valid is high at edge N, s and c show that result after edge N and out_valid is high for the following cycle.
REQ-015 When in_valid is low at an edge, s and c hold their previous values and out_valid goes low.
REQ-016 Back-to-back valid inputs are accepted every cycle, giving full throughput. There is no backpressure.
REQ-017 The inputs a and b are ignored while in_valid is low, including X values on them.
REQ-018 Counter (with the macro only): on each accepted input, carry_cnt increases by the popcount of the per-lane carries of that input.
REQ-019 The counter saturates at 2^CNT_W-1 and never wraps.
REQ-020 cnt_clr has priority over counting in the same cycle: the counter becomes 0 and that cycle's increment is discarded.

Reset
REQ-021 While rst is high, s=0, c=0 and out_valid=0 immediately, without waiting for a clock edge. carry_cnt=0 as well when present.
REQ-022 A transaction in flight when rst asserts is dropped, and no out_valid pulse is produced for it.
REQ-023 The first input is accepted at the first rising clk edge after rst deasserts.

Configuration
REQ-024 Macro HALF_ADDER_CARRY_CNT_EN defined: the cnt_clr and carry_cnt ports and the counter logic of REQ-018 to REQ-020 are compiled in.
REQ-025 Macro HALF_ADDER_CARRY_CNT_EN undefined: those ports and that logic are absent, and the behaviour of s, c and out_valid is identical to the defined case.

Structure
REQ-026 Shared package half_adder_pkg holds the default constants for WIDTH and CNT_W.
REQ-027 The package also holds a popcount function, or a constant, used for the counter increment width of ceil(log2(WIDTH+1)) bits.
REQ-028 There is one combinational sub-module, half_adder_cell (1-bit a, b -> s, c), instantiated WIDTH times through a generate loop.
REQ-029 The top level contains only the output registers, the valid register and the optional counter.

Verification
REQ-030 WIDTH=1 sequence, one input every 10 time units: (a,b) = 00, 01, 10, 11 with in_valid=1 -> (s,c) = 00, 10, 10, 01 one cycle later each, with out_valid high each cycle.
REQ-031 WIDTH=4: a=4'b1100, b=4'b1010, in_valid=1 -> s=4'b0110, c=4'b1000 next cycle. With the macro, carry_cnt increases by 1.
REQ-032 in_valid=1 for one cycle, then 0 with a, b toggling -> s and c hold the first result, and out_valid is high for exactly 1 cycle.
REQ-033 rst asserted mid-cycle after a valid input with a=b=1 -> s=c=0 and out_valid=0 before the next edge, and there is no later result pulse.
REQ-034 Macro on, CNT_W=4, WIDTH=4, a=b=4'hF valid for 5 cycles -> carry_cnt sequence 4, 8, 12, 15, 15, saturating.
REQ-035 Macro on, cnt_clr=1 in the same cycle as a valid input with carries -> carry_cnt=0 next cycle.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared constants and helpers for the half_adder block.
// Holds the default lane count, the default carry counter width and the
// helpers that size and compute the per-transaction carry increment.
package half_adder_pkg;

    // Default number of independent half-adder lanes.
    localparam int HA_DEFAULT_WIDTH = 1;

    // Default width of the carry event counter.
    localparam int HA_DEFAULT_CNT_W = 16;

    // Widest lane vector the block supports.
    localparam int HA_MAX_WIDTH = 64;

    // Width of a popcount result over the widest lane vector (0..64 needs 7 bits).
    localparam int HA_POP_W = 7;

    // Bits needed to hold a carry increment for a given lane count:
    // ceil(log2(width+1)), so that "all lanes carry" is representable.
    function automatic int inc_width(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

    // Number of set bits in a lane vector, zero-extended to the widest size.
    function automatic logic [HA_POP_W-1:0] popcount64(input logic [HA_MAX_WIDTH-1:0] v);
        logic [HA_POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < HA_MAX_WIDTH; i++) begin
            n = n + HA_POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One combinational half-adder lane: sum is the XOR, carry the AND.
// No state, no clock; the top level registers the results.
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder.sv
// Registered, multi-lane half adder with an optional carry event counter.
//
// Optional feature macro: HALF_ADDER_CARRY_CNT_EN
//   defined   -> cnt_clr / carry_cnt ports and the saturating carry counter
//   undefined -> those ports and that logic are absent; s, c, out_valid unchanged
//
// Handshake: a transfer happens on every rising clk edge where in_valid is
// high. There is no ready signal; the block accepts a new input every cycle.
// out_valid is high for exactly the one cycle after each accepted input, and
// s/c keep the last accepted result while out_valid is low. a and b are
// don't-care (X allowed) whenever in_valid is low.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = HA_DEFAULT_WIDTH,
    parameter int CNT_W = HA_DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic             out_valid
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Elaboration-time guards on the legal parameter ranges.
    if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH) begin : g_width_check
        $error("half_adder: WIDTH must be in 1..64");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("half_adder: CNT_W must be at least 1");
    end

    // Combinational per-lane results feeding the output registers.
    logic [WIDTH-1:0] s_comb;
    logic [WIDTH-1:0] c_comb;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .s (s_comb[i]),
            .c (c_comb[i])
        );
    end

    // Result registers: load only on an accepted input, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
            c <= '0;
        end else if (in_valid) begin
            s <= s_comb;
            c <= c_comb;
        end
    end

    // Valid register: one-cycle pulse following each accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

`ifdef HALF_ADDER_CARRY_CNT_EN
    // Increment is the number of lanes that carry in this input. The sum is
    // formed one bit wider than either operand so the saturation compare
    // never sees a wrapped value.
    localparam int INC_W = inc_width(WIDTH);
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    logic [INC_W-1:0] carry_inc;
    logic [SUM_W-1:0] cnt_sum;
    logic [SUM_W-1:0] cnt_max;

    assign carry_inc = INC_W'(popcount64(HA_MAX_WIDTH'(c_comb)));
    assign cnt_sum   = SUM_W'(carry_cnt) + SUM_W'(carry_inc);
    assign cnt_max   = SUM_W'({CNT_W{1'b1}});

    // Saturating carry counter; a clear wins over that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_cnt <= '0;
        end else if (cnt_clr) begin
            carry_cnt <= '0;
        end else if (in_valid) begin
            if (cnt_sum > cnt_max) begin
                carry_cnt <= {CNT_W{1'b1}};
            end else begin
                carry_cnt <= cnt_sum[CNT_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed bench for half_adder: a 1-lane instance and a 4-lane instance
// with a 4-bit counter share one clock and reset.
module tb_half_adder;

    logic clk;
    logic rst;

    logic       a1, b1, v1;
    logic       s1, c1, ov1;

    logic [3:0] a4, b4;
    logic       v4;
    logic [3:0] s4, c4;
    logic       ov4;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic       clr1, clr4;
    logic [15:0] cnt1;
    logic [3:0] cnt4;
`endif

    int pass_cnt;
    int total_cnt;

    half_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .in_valid  (v1),
        .s         (s1),
        .c         (c1),
        .out_valid (ov1)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .cnt_clr   (clr1),
        .carry_cnt (cnt1)
`endif
    );

    half_adder #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .a         (a4),
        .b         (b4),
        .in_valid  (v4),
        .s         (s4),
        .c         (c4),
        .out_valid (ov4)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .cnt_clr   (clr4),
        .carry_cnt (cnt4)
`endif
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
`ifdef HALF_ADDER_CARRY_CNT_EN
        clr1 = 1'b0; clr4 = 1'b0;
`endif
        #2;
        total_cnt++;
        if ({s1, c1, ov1, s4, c4, ov4} !== 11'b0) begin
            $display("FAIL reset_before_edge: got %b expected all zero", {s1, c1, ov1, s4, c4, ov4});
        end else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({s1, c1, ov1, s4, c4, ov4} !== 11'b0) begin
            $display("FAIL reset_held: got %b expected all zero", {s1, c1, ov1, s4, c4, ov4});
        end else pass_cnt++;
`ifdef HALF_ADDER_CARRY_CNT_EN
        total_cnt++;
        if (cnt4 !== 4'd0 || cnt1 !== 16'd0) begin
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt4, cnt1);
        end else pass_cnt++;
`endif
        v1 = 1'b0; v4 = 1'b0;
        rst = 1'b0;
    endtask

    // First input right after reset release, then back-to-back lanes.
    task automatic test_width1();
        logic [1:0] ab_tab [4];
        logic [1:0] sc_tab [4];
        ab_tab = '{2'b00, 2'b01, 2'b10, 2'b11};
        sc_tab = '{2'b00, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = ab_tab[i];
            v1 = 1'b1;
            @(posedge clk); #1;
            total_cnt++;
            if ({s1, c1, ov1} !== {sc_tab[i], 1'b1}) begin
                $display("FAIL width1_vec%0d: got s,c,ov=%b expected %b", i, {s1, c1, ov1}, {sc_tab[i], 1'b1});
            end else pass_cnt++;
        end
        v1 = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({s1, c1, ov1} !== 3'b010) begin
            $display("FAIL width1_idle: got s,c,ov=%b expected 010", {s1, c1, ov1});
        end else pass_cnt++;
    endtask

    task automatic test_width4();
        a4 = 4'b1100; b4 = 4'b1010; v4 = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({s4, c4, ov4} !== {4'b0110, 4'b1000, 1'b1}) begin
            $display("FAIL width4_a: got s=%b c=%b ov=%b expected s=0110 c=1000 ov=1", s4, c4, ov4);
        end else pass_cnt++;
`ifdef HALF_ADDER_CARRY_CNT_EN
        total_cnt++;
        if (cnt4 !== 4'd1) begin
            $display("FAIL width4_a_cnt: got %0d expected 1", cnt4);
        end else pass_cnt++;
`endif
        a4 = 4'b0111; b4 = 4'b0101;
        @(posedge clk); #1;
        total_cnt++;
        if ({s4, c4, ov4} !== {4'b0010, 4'b0101, 1'b1}) begin
            $display("FAIL width4_b: got s=%b c=%b ov=%b expected s=0010 c=0101 ov=1", s4, c4, ov4);
        end else pass_cnt++;
`ifdef HALF_ADDER_CARRY_CNT_EN
        total_cnt++;
        if (cnt4 !== 4'd3) begin
            $display("FAIL width4_b_cnt: got %0d expected 3", cnt4);
        end else pass_cnt++;
`endif
        v4 = 1'b0;
    endtask

    // One valid cycle, then idle cycles with a, b toggling or unknown.
    task automatic test_hold();
        a4 = 4'b0011; b4 = 4'b0110; v4 = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if ({s4, c4, ov4} !== {4'b0101, 4'b0010, 1'b1}) begin
            $display("FAIL hold_first: got s=%b c=%b ov=%b expected s=0101 c=0010 ov=1", s4, c4, ov4);
        end else pass_cnt++;
        v4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4 = ~a4;
            b4 = (i == 1) ? 4'bx10x : ~b4;
            @(posedge clk); #1;
            total_cnt++;
            if ({s4, c4, ov4} !== {4'b0101, 4'b0010, 1'b0}) begin
                $display("FAIL hold_idle%0d: got s=%b c=%b ov=%b expected s=0101 c=0010 ov=0", i, s4, c4, ov4);
            end else pass_cnt++;
        end
    endtask

    // Reset lands mid-cycle while an a=b=1 result is on the outputs.
    task automatic test_reset_inflight();
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({s1, c1, ov1, s4, c4, ov4} !== 11'b0) begin
            $display("FAIL rst_midcycle: got %b expected all zero", {s1, c1, ov1, s4, c4, ov4});
        end else pass_cnt++;
`ifdef HALF_ADDER_CARRY_CNT_EN
        total_cnt++;
        if (cnt4 !== 4'd0) begin
            $display("FAIL rst_midcycle_cnt: got %0d expected 0", cnt4);
        end else pass_cnt++;
`endif
        v1 = 1'b0; v4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if ({s1, c1, ov1, s4, c4, ov4} !== 11'b0) begin
                $display("FAIL rst_no_pulse%0d: got %b expected all zero", i, {s1, c1, ov1, s4, c4, ov4});
            end else pass_cnt++;
        end
    endtask

`ifdef HALF_ADDER_CARRY_CNT_EN
    task automatic test_saturate();
        logic [3:0] sat_tab [5];
        sat_tab = '{4'd4, 4'd8, 4'd12, 4'd15, 4'd15};
        a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (cnt4 !== sat_tab[i]) begin
                $display("FAIL saturate%0d: got %0d expected %0d", i, cnt4, sat_tab[i]);
            end else pass_cnt++;
        end
        v4 = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (cnt4 !== 4'd15) begin
            $display("FAIL saturate_hold: got %0d expected 15", cnt4);
        end else pass_cnt++;
    endtask

    task automatic test_clr_priority();
        a4 = 4'hF; b4 = 4'hF; v4 = 1'b1; clr4 = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (cnt4 !== 4'd0 || c4 !== 4'hF || ov4 !== 1'b1) begin
            $display("FAIL clr_priority: got cnt=%0d c=%b ov=%b expected cnt=0 c=1111 ov=1", cnt4, c4, ov4);
        end else pass_cnt++;
        clr4 = 1'b0;
        a4 = 4'b1100; b4 = 4'b1010;
        @(posedge clk); #1;
        total_cnt++;
        if (cnt4 !== 4'd1) begin
            $display("FAIL clr_then_count: got %0d expected 1", cnt4);
        end else pass_cnt++;
        v4 = 1'b0;
    endtask
`endif

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_width1();
        test_width4();
        test_hold();
        test_reset_inflight();
`ifdef HALF_ADDER_CARRY_CNT_EN
        test_saturate();
        test_clr_priority();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
